// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared constants for the RV32M multiply controller.
// Holds the operand width, the funct3[1:0] op encodings, the multiplier
// sign-extend mode encodings, the result-half select values, the
// controller FSM state constants, and the op-decode helpers.
package mul_ctrl_pkg;

    localparam int XLEN = 32;

    // funct3[1:0] of the M-extension multiply group
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Multiplier sign-extend modes; UNSIGNED_UNSIGNED is the all-zero idle value
    localparam logic [1:0] SIGNED_SIGNED     = 2'b11;
    localparam logic [1:0] UNSIGNED_SIGNED   = 2'b10;
    localparam logic [1:0] UNSIGNED_UNSIGNED = 2'b00;

    // Result half select
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    // MULHSU: rs1 signed, rs2 unsigned
    function automatic logic [1:0] op_sign_mode(input logic [1:0] op);
        case (op)
            OP_MUL, OP_MULH: op_sign_mode = SIGNED_SIGNED;
            OP_MULHSU:       op_sign_mode = UNSIGNED_SIGNED;
            OP_MULHU:        op_sign_mode = UNSIGNED_UNSIGNED;
            default:         op_sign_mode = UNSIGNED_UNSIGNED;
        endcase
    endfunction

    function automatic logic op_word_sel(input logic [1:0] op);
        op_word_sel = (op == OP_MUL) ? LOW : HIGH;
    endfunction

endpackage

// File: rtl/mul_result_cache.sv
// mul_result_cache: one-entry cache of the last completed 64-bit product.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rs1, rs2, mode        lookup key of the current request
//   is_mul                request is MUL (low half, mode-independent)
//   hit, hit_data         lookup result and the requested half
//   wr_en, wr_hi, wr_data write one half of the product
//   tag_en                commit tag {tag_rs1, tag_rs2, tag_mode} and set valid
module mul_result_cache
    import mul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [1:0]      mode,
    input  logic            is_mul,
    output logic            hit,
    output logic [XLEN-1:0] hit_data,
    input  logic            wr_en,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wr_data,
    input  logic            tag_en,
    input  logic [XLEN-1:0] tag_rs1,
    input  logic [XLEN-1:0] tag_rs2,
    input  logic [1:0]      tag_mode
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] t_rs1_q;
    logic [XLEN-1:0] t_rs2_q;
    logic [1:0]      t_mode_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            t_rs1_q  <= '0;
            t_rs2_q  <= '0;
            t_mode_q <= UNSIGNED_UNSIGNED;
            valid_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_hi) hi_q <= wr_data;
                else       lo_q <= wr_data;
            end
            if (tag_en) begin
                t_rs1_q  <= tag_rs1;
                t_rs2_q  <= tag_rs2;
                t_mode_q <= tag_mode;
                valid_q  <= 1'b1;
            end
        end
    end

    // The low half of the product is the same for every sign mode, so a MUL
    // may hit on an entry produced by any of the high-half ops.
    always_comb begin
        hit      = valid_q && (rs1 == t_rs1_q) && (rs2 == t_rs2_q)
                   && ((mode == t_mode_q) || is_mul);
        hit_data = is_mul ? lo_q : hi_q;
    end

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: EX-stage issue/sequencing controller for the RV32M multiply path.
// Decodes MUL/MULH/MULHSU/MULHU, drives the 4-cycle pipelined multiplier,
// stalls IF..EX until completion and returns the selected half to writeback.
// A one-entry result cache serves the other half of the last product at once.
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   pipe_flush            aborts an in-flight multiply
//   ex_mul_req, ex_mul_op valid multiply in EX and its funct3[1:0]
//   rs1_data, rs2_data    source operands
//   mul_done, mul_res     multiplier completion and selected result half
//   ex_is_mul_inst        multiplier enable
//   ex_word_sel           HIGH selects product[63:32]
//   ex_sign_extend        multiplier sign mode
//   m1, m2                multiplier operands
//   mul_stall             hold IF..EX
//   mul_wb_valid/_data    result to writeback
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            ex_mul_req,
    input  logic [1:0]      ex_mul_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_res,
    output logic            ex_is_mul_inst,
    output logic            ex_word_sel,
    output logic [1:0]      ex_sign_extend,
    output logic [XLEN-1:0] m1,
    output logic [XLEN-1:0] m2,
    output logic            mul_stall,
    output logic            mul_wb_valid,
    output logic [XLEN-1:0] mul_wb_data
);

    logic [1:0]      state_q;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] lat_m1_q;
    logic [XLEN-1:0] lat_m2_q;
    logic [1:0]      lat_mode_q;
    logic            lat_hi_q;

    logic [1:0]      req_mode;
    logic            req_hi;
    logic            req_is_mul;
    logic            issue;

    logic            c_hit;
    logic [XLEN-1:0] c_data;
    logic            c_wr_en;
    logic            c_wr_hi;
    logic            c_tag_en;

    assign req_mode   = op_sign_mode(ex_mul_op);
    assign req_hi     = op_word_sel(ex_mul_op);
    assign req_is_mul = (ex_mul_op == OP_MUL);
    assign issue      = ex_mul_req && !pipe_flush;

    mul_result_cache u_cache (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1_data),
        .rs2      (rs2_data),
        .mode     (req_mode),
        .is_mul   (req_is_mul),
        .hit      (c_hit),
        .hit_data (c_data),
        .wr_en    (c_wr_en),
        .wr_hi    (c_wr_hi),
        .wr_data  (mul_res),
        .tag_en   (c_tag_en),
        .tag_rs1  (lat_m1_q),
        .tag_rs2  (lat_m2_q),
        .tag_mode (lat_mode_q)
    );

    always_comb begin
        state_nxt      = state_q;
        ex_is_mul_inst = 1'b0;
        ex_word_sel    = LOW;
        ex_sign_extend = UNSIGNED_UNSIGNED;
        m1             = '0;
        m2             = '0;
        mul_stall      = 1'b0;
        mul_wb_valid   = 1'b0;
        mul_wb_data    = '0;
        c_wr_en        = 1'b0;
        c_wr_hi        = LOW;
        c_tag_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (c_hit) begin
                        mul_wb_valid = 1'b1;
                        mul_wb_data  = c_data;
                    end else begin
                        // Pass operands straight through so the multiplier
                        // starts in the request cycle.
                        ex_is_mul_inst = 1'b1;
                        m1             = rs1_data;
                        m2             = rs2_data;
                        ex_sign_extend = req_mode;
                        ex_word_sel    = req_hi;
                        mul_stall      = 1'b1;
                        state_nxt      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                ex_is_mul_inst = 1'b1;
                m1             = lat_m1_q;
                m2             = lat_m2_q;
                ex_sign_extend = lat_mode_q;
                ex_word_sel    = lat_hi_q;
                mul_stall      = !mul_done;
                if (pipe_flush) begin
                    state_nxt = ST_IDLE;
                end else if (mul_done) begin
                    mul_wb_valid = 1'b1;
                    mul_wb_data  = mul_res;
                    c_wr_en      = 1'b1;
                    c_wr_hi      = lat_hi_q;
                    state_nxt    = ST_CAPT;
                end
            end
            ST_CAPT: begin
                // Enable drops so the multiplier's counter clears; its sum is
                // held, so flipping the half select reads the other word.
                m1             = lat_m1_q;
                m2             = lat_m2_q;
                ex_sign_extend = lat_mode_q;
                ex_word_sel    = !lat_hi_q;
                mul_stall      = ex_mul_req;
                c_wr_en        = 1'b1;
                c_wr_hi        = !lat_hi_q;
                c_tag_en       = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are forced to zero while reset is held, independent of
        // whatever request is presented during reset.
        if (!rst_n) begin
            ex_is_mul_inst = 1'b0;
            ex_word_sel    = LOW;
            ex_sign_extend = UNSIGNED_UNSIGNED;
            m1             = '0;
            m2             = '0;
            mul_stall      = 1'b0;
            mul_wb_valid   = 1'b0;
            mul_wb_data    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Operand latches load only on the IDLE-to-BUSY transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_m1_q   <= '0;
            lat_m2_q   <= '0;
            lat_mode_q <= UNSIGNED_UNSIGNED;
            lat_hi_q   <= LOW;
        end else if (state_q == ST_IDLE && issue && !c_hit) begin
            lat_m1_q   <= rs1_data;
            lat_m2_q   <= rs2_data;
            lat_mode_q <= req_mode;
            lat_hi_q   <= req_hi;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed scoreboard bench for mul_ctrl with a behavioural
// 4-cycle multiplier model driving mul_done / mul_res.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_flush = 1'b0;
    logic        ex_mul_req = 1'b0;
    logic [1:0]  ex_mul_op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        mul_done;
    logic [31:0] mul_res;
    logic        ex_is_mul_inst;
    logic        ex_word_sel;
    logic [1:0]  ex_sign_extend;
    logic [31:0] m1;
    logic [31:0] m2;
    logic        mul_stall;
    logic        mul_wb_valid;
    logic [31:0] mul_wb_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mul_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_flush     (pipe_flush),
        .ex_mul_req     (ex_mul_req),
        .ex_mul_op      (ex_mul_op),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .mul_done       (mul_done),
        .mul_res        (mul_res),
        .ex_is_mul_inst (ex_is_mul_inst),
        .ex_word_sel    (ex_word_sel),
        .ex_sign_extend (ex_sign_extend),
        .m1             (m1),
        .m2             (m2),
        .mul_stall      (mul_stall),
        .mul_wb_valid   (mul_wb_valid),
        .mul_wb_data    (mul_wb_data)
    );

    // Multiplier model: done in the 4th consecutive enabled cycle; the product
    // is combinational from the operands so a held sum can be re-read.
    logic [2:0]  mcnt = '0;
    logic [63:0] a_ext, b_ext, prod;

    always @(posedge clk) begin
        if (!ex_is_mul_inst)  mcnt <= '0;
        else if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
    end

    assign mul_done = ex_is_mul_inst && (mcnt == 3'd3);

    always_comb begin
        a_ext = (ex_sign_extend != UNSIGNED_UNSIGNED) ? {{32{m1[31]}}, m1} : {32'b0, m1};
        b_ext = (ex_sign_extend == SIGNED_SIGNED)     ? {{32{m2[31]}}, m2} : {32'b0, m2};
        prod  = a_ext * b_ext;
    end

    assign mul_res = ex_word_sel ? prod[63:32] : prod[31:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ex_mul_req = 1'b0;
        pipe_flush = 1'b0;
        repeat (n) cycle();
    endtask

    // Presents one request until the stall releases. exp_lat is the cycle
    // index of the result (0 hit, 1 hit behind a capture, 3 miss).
    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
        int  cyc;
        int  wb_cyc;
        bit  fin;
        logic [31:0] got;
        sb.push_back(exp_data);
        ex_mul_req = 1'b1;
        ex_mul_op  = op;
        rs1_data   = a;
        rs2_data   = b;
        cyc    = 0;
        wb_cyc = -1;
        fin    = 1'b0;
        while (!fin && cyc < 10) begin
            @(negedge clk);
            chk({tag, "_inst"}, {31'b0, ex_is_mul_inst}, {31'b0, exp_lat == 3});
            if (cyc == 0 && exp_lat == 3) begin
                chk({tag, "_m1"}, m1, a);
                chk({tag, "_m2"}, m2, b);
            end
            if (mul_wb_valid) begin
                wb_cyc = cyc;
                chk({tag, "_sbdepth"}, sb.size(), 1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk({tag, "_data"}, mul_wb_data, got);
                end
            end
            if (!mul_stall) fin = 1'b1;
            else begin
                cycle();
                cyc++;
            end
        end
        chk({tag, "_stall"}, cyc, exp_lat);
        chk({tag, "_wbcyc"}, wb_cyc, exp_lat);
        cycle();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_inst",  {31'b0, ex_is_mul_inst}, 32'd0);
        chk("rst_wsel",  {31'b0, ex_word_sel}, 32'd0);
        chk("rst_sign",  {30'b0, ex_sign_extend}, {30'b0, UNSIGNED_UNSIGNED});
        chk("rst_m1",    m1, 32'd0);
        chk("rst_m2",    m2, 32'd0);
        chk("rst_stall", {31'b0, mul_stall}, 32'd0);
        chk("rst_wbv",   {31'b0, mul_wb_valid}, 32'd0);
        #10 rst_n = 1'b1;
        cycle();

        // Cold miss then hit on the other half
        do_req("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
        idle(1);
        do_req("mul_ff_hit", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        idle(1);

        do_req("mulh_80", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 3);
        idle(1);
        do_req("mul_80_hit", OP_MUL, 32'h80000000, 32'h80000000, 32'h00000000, 0);
        idle(1);

        // Differing mode must miss for a high-half op
        do_req("mulhsu_ff", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        idle(1);
        do_req("mulhu_ff_miss", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
        idle(1);

        // Flush in BUSY at t+2
        ex_mul_req = 1'b1; ex_mul_op = OP_MUL; rs1_data = 32'd3; rs2_data = 32'd5;
        @(negedge clk);
        chk("fl_t0_inst", {31'b0, ex_is_mul_inst}, 32'd1);
        chk("fl_t0_stall", {31'b0, mul_stall}, 32'd1);
        cycle();
        @(negedge clk);
        chk("fl_t1_wbv", {31'b0, mul_wb_valid}, 32'd0);
        cycle();
        pipe_flush = 1'b1; ex_mul_req = 1'b0;
        @(negedge clk);
        chk("fl_t2_wbv", {31'b0, mul_wb_valid}, 32'd0);
        cycle();
        pipe_flush = 1'b0;
        @(negedge clk);
        chk("fl_t3_inst", {31'b0, ex_is_mul_inst}, 32'd0);
        chk("fl_t3_wbv", {31'b0, mul_wb_valid}, 32'd0);
        chk("fl_t3_stall", {31'b0, mul_stall}, 32'd0);
        cycle();
        do_req("mul_3x5_retry", OP_MUL, 32'd3, 32'd5, 32'h0000000F, 3);
        idle(1);

        // Flush coincident with mul_done
        ex_mul_req = 1'b1; ex_mul_op = OP_MUL; rs1_data = 32'd7; rs2_data = 32'd9;
        repeat (3) cycle();
        pipe_flush = 1'b1; ex_mul_req = 1'b0;
        @(negedge clk);
        chk("fd_done", {31'b0, mul_done}, 32'd1);
        chk("fd_wbv", {31'b0, mul_wb_valid}, 32'd0);
        cycle();
        pipe_flush = 1'b0;
        @(negedge clk);
        chk("fd_inst", {31'b0, ex_is_mul_inst}, 32'd0);
        chk("fd_wbv2", {31'b0, mul_wb_valid}, 32'd0);
        cycle();

        // Request arriving in CAPT: one extra stall, then a hit
        do_req("mulhu_f2", OP_MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 3);
        do_req("mul_f2_capt", OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1);
        idle(2);

        // Reset while BUSY
        ex_mul_req = 1'b1; ex_mul_op = OP_MUL; rs1_data = 32'h12345678; rs2_data = 32'h10;
        cycle();
        #1 rst_n = 1'b0;
        #1;
        chk("rb_inst",  {31'b0, ex_is_mul_inst}, 32'd0);
        chk("rb_wsel",  {31'b0, ex_word_sel}, 32'd0);
        chk("rb_sign",  {30'b0, ex_sign_extend}, {30'b0, UNSIGNED_UNSIGNED});
        chk("rb_m1",    m1, 32'd0);
        chk("rb_m2",    m2, 32'd0);
        chk("rb_stall", {31'b0, mul_stall}, 32'd0);
        chk("rb_wbv",   {31'b0, mul_wb_valid}, 32'd0);
        chk("rb_wbd",   mul_wb_data, 32'd0);
        ex_mul_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle();
        do_req("mul_f2_after_rst", OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 3);
        idle(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
